axis_uart_tx_arbiter: RTL

- Packet-level round-robin arbiter that shares one axis_uart TX slave stream (8-bit AXIS) among NUM_PORTS byte requesters.
- Holds a grant until the requester ends its packet (tlast) or sends MAX_BURST bytes, whichever comes first.
- After each grant it can insert an optional idle gap so the far end sees packet separation on the line.
- Sits between software/DMA byte sources and the axis_uart s_axis port.

---
 rtl/axis_uart_tx_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/axis_uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one axis_uart TX byte stream among NUM_PORTS sources.
// A grant lasts until tlast or MAX_BURST beats, optionally followed by a GAP_CYCLES idle gap.
module axis_uart_tx_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int MAX_BURST  = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic                         aclk,
  input  logic                         arst,
  input  logic [NUM_PORTS*8-1:0]       s_axis_tdata,
  input  logic [NUM_PORTS-1:0]         s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]         s_axis_tlast,
  output logic [NUM_PORTS-1:0]         s_axis_tready,
  output logic [7:0]                   m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [$clog2(NUM_PORTS)-1:0] grant_port,
  output logic                         busy
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [PW-1:0]   grant_r;
  logic [PW-1:0]   pick_s;
  logic [PW-1:0]   idx_s;
  logic            pick_vld_s;
  logic [BW-1:0]   burst_cnt_r;
  logic [15:0]     gap_cnt_r;
  logic            beat_s;
  logic            grant_end_s;

  assign grant_port = grant_r;

  // Round-robin pick: scan downward so the nearest port above grant_r is assigned last and wins.
  always_comb begin
    pick_vld_s = 1'b0;
    pick_s     = grant_r;
    idx_s      = grant_r;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx_s = PW'((int'(grant_r) + k) % NUM_PORTS);
      if (s_axis_tvalid[idx_s]) begin
        pick_vld_s = 1'b1;
        pick_s     = idx_s;
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
  end

  // Beat and end-of-grant detection for the granted port.
  always_comb begin
    beat_s      = (state_r == ST_GRANT) && s_axis_tvalid[grant_r] && m_axis_tready;
    grant_end_s = beat_s && (s_axis_tlast[grant_r] || (burst_cnt_r == BW'(MAX_BURST - 1)));
  end

  // State register.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_vld_s) begin
          state_nxt_s = ST_GRANT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (grant_end_s) begin
          state_nxt_s = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == 16'd0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Grant index, burst counter and gap counter; gap loads GAP_CYCLES-1 so GAP lasts GAP_CYCLES cycles.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      grant_r     <= PW'(NUM_PORTS - 1);
      burst_cnt_r <= {BW{1'b0}};
      gap_cnt_r   <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_vld_s) begin
            grant_r     <= pick_s;
            burst_cnt_r <= {BW{1'b0}};
          end
        end
        ST_GRANT: begin
          if (beat_s) begin
            burst_cnt_r <= burst_cnt_r + BW'(1);
          end
          if (grant_end_s && (GAP_CYCLES > 0)) begin
            gap_cnt_r <= 16'(GAP_CYCLES - 1);
          end
        end
        ST_GAP: begin
          if (gap_cnt_r != 16'd0) begin
            gap_cnt_r <= gap_cnt_r - 16'd1;
          end
        end
        default: begin
          burst_cnt_r <= {BW{1'b0}};
        end
      endcase
    end
  end

  // Outputs: combinational passthrough of the granted port while in GRANT, quiet otherwise.
  always_comb begin
    s_axis_tready = {NUM_PORTS{1'b0}};
    m_axis_tdata  = 8'h00;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    busy          = (state_r != ST_IDLE);
    if (state_r == ST_GRANT) begin
      m_axis_tdata           = s_axis_tdata[{grant_r, 3'b000} +: 8];
      m_axis_tvalid          = s_axis_tvalid[grant_r];
      m_axis_tlast           = s_axis_tlast[grant_r];
      s_axis_tready[grant_r] = m_axis_tready;
    end else begin
      m_axis_tvalid = 1'b0;
    end
  end

endmodule
